regfile_write_arbiter: RTL and testbench

- Shares the single write port of the 32x32 register file between two writeback requesters: req0 (ALU writeback) and req1 (load/memory writeback).
- Arbitrates round-robin, or fixed-priority by parameter, with a valid/ready handshake.
- Registers the granted write into a one-entry output stage that drives the register file's rd, dataIn and writeEn.
- Provides forwarding-hit flags for the in-flight staged write to the two read ports.

---
 rtl/regfile_write_arbiter.sv | 118 +++++++++++
 tb/tb_regfile_write_arbiter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// Two-requester write-port arbiter for the 32x32 register file: round-robin or
// fixed-priority grant, one-entry staged write, and forwarding-hit flags.
module regfile_write_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int FIXED_PRIO = 0
) (
  input  logic                  clk,
  input  logic                  r,
  input  logic                  hold,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [ADDR_WIDTH-1:0] req0_rd,
  input  logic [DATA_WIDTH-1:0] req0_data,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [ADDR_WIDTH-1:0] req1_rd,
  input  logic [DATA_WIDTH-1:0] req1_data,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_rd,
  output logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rs1,
  input  logic [ADDR_WIDTH-1:0] rs2,
  output logic                  fwd_a_hit,
  output logic                  fwd_b_hit,
  output logic                  last_grant
);

  logic [1:0]            req_valid;
  logic [1:0]            grant;
  logic                  transfer;
  logic                  winner;
  logic [ADDR_WIDTH-1:0] winner_rd;
  logic [DATA_WIDTH-1:0] winner_data;

  logic                  ptr_reg, ptr_next;
  logic                  en_reg, en_next;
  logic [ADDR_WIDTH-1:0] rd_reg, rd_next;
  logic [DATA_WIDTH-1:0] data_reg, data_next;
  logic                  last_reg, last_next;

  logic [ADDR_WIDTH-1:0] rs_vec [2];
  logic [1:0]            fwd_hit;

  assign req_valid = {req1_valid, req0_valid};

  // Grant is purely combinational; reset and hold both suppress every ready.
  always_comb begin
    grant = 2'b00;
    if (!r && !hold) begin
      unique case (req_valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = ((FIXED_PRIO != 0) || !ptr_reg) ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

  assign transfer    = |grant;
  assign winner      = grant[1];
  assign winner_rd   = winner ? req1_rd : req0_rd;
  assign winner_data = winner ? req1_data : req0_data;

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];

  // Staged write: en is a one-cycle pulse, rd/data hold between transfers.
  always_comb begin
    ptr_next  = ptr_reg;
    en_next   = 1'b0;
    rd_next   = rd_reg;
    data_next = data_reg;
    last_next = last_reg;
    if (transfer) begin
      rd_next   = winner_rd;
      data_next = winner_data;
      en_next   = (winner_rd != '0);
      last_next = winner;
      ptr_next  = ~winner;
    end
  end

  always_ff @(posedge clk) begin
    if (r) begin
      ptr_reg  <= 1'b0;
      en_reg   <= 1'b0;
      rd_reg   <= '0;
      data_reg <= '0;
      last_reg <= 1'b0;
    end else begin
      ptr_reg  <= ptr_next;
      en_reg   <= en_next;
      rd_reg   <= rd_next;
      data_reg <= data_next;
      last_reg <= last_next;
    end
  end

  assign wr_en      = en_reg;
  assign wr_rd      = rd_reg;
  assign wr_data    = data_reg;
  assign last_grant = last_reg;

  assign rs_vec[0] = rs1;
  assign rs_vec[1] = rs2;

  // x0 is hardwired zero, so a read of x0 never forwards.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      assign fwd_hit[gi] = en_reg && (rd_reg == rs_vec[gi]) && (rs_vec[gi] != '0);
    end
  endgenerate

  assign fwd_a_hit = fwd_hit[0];
  assign fwd_b_hit = fwd_hit[1];

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: round-robin and fixed-priority instances
// share stimulus; each is checked against its own behavioural model.
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        r_in, hold;
  logic        v0, v1;
  logic [4:0]  rd0, rd1, rs1, rs2;
  logic [31:0] d0, d1;

  logic [1:0]  rdy0, rdy1, wen, fa, fb, lg;
  logic [4:0]  wrd [2];
  logic [31:0] wdat [2];

  int checks = 0;
  int errors = 0;

  // model state, index 0 = round-robin instance, 1 = fixed-priority instance
  logic        m_ptr [2];
  logic        m_en  [2];
  logic [4:0]  m_rd  [2];
  logic [31:0] m_dat [2];
  logic        m_last[2];
  logic [1:0]  g_exp [2];

  always #5 clk = ~clk;

  regfile_write_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .FIXED_PRIO(0)) u_rr (
    .clk(clk), .r(r_in), .hold(hold),
    .req0_valid(v0), .req0_ready(rdy0[0]), .req0_rd(rd0), .req0_data(d0),
    .req1_valid(v1), .req1_ready(rdy1[0]), .req1_rd(rd1), .req1_data(d1),
    .wr_en(wen[0]), .wr_rd(wrd[0]), .wr_data(wdat[0]),
    .rs1(rs1), .rs2(rs2), .fwd_a_hit(fa[0]), .fwd_b_hit(fb[0]), .last_grant(lg[0])
  );

  regfile_write_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .FIXED_PRIO(1)) u_fp (
    .clk(clk), .r(r_in), .hold(hold),
    .req0_valid(v0), .req0_ready(rdy0[1]), .req0_rd(rd0), .req0_data(d0),
    .req1_valid(v1), .req1_ready(rdy1[1]), .req1_rd(rd1), .req1_data(d1),
    .wr_en(wen[1]), .wr_rd(wrd[1]), .wr_data(wdat[1]),
    .rs1(rs1), .rs2(rs2), .fwd_a_hit(fa[1]), .fwd_b_hit(fb[1]), .last_grant(lg[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Which requester the rules select this cycle (bit0 = req0, bit1 = req1).
  function automatic logic [1:0] exp_grant(input int i);
    if (r_in || hold) return 2'b00;
    if (v0 && v1) return (i == 1 || !m_ptr[i]) ? 2'b01 : 2'b10;
    if (v0) return 2'b01;
    if (v1) return 2'b10;
    return 2'b00;
  endfunction

  // One clock cycle with the inputs currently applied.
  task automatic cycle();
    string nm;
    #1;
    for (int i = 0; i < 2; i++) begin
      nm = (i == 0) ? "rr" : "fp";
      g_exp[i] = exp_grant(i);
      check({nm, " req0_ready"}, {31'd0, rdy0[i]}, {31'd0, g_exp[i][0]});
      check({nm, " req1_ready"}, {31'd0, rdy1[i]}, {31'd0, g_exp[i][1]});
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      nm = (i == 0) ? "rr" : "fp";
      if (r_in) begin
        m_ptr[i] = 1'b0; m_en[i] = 1'b0; m_rd[i] = '0; m_dat[i] = '0; m_last[i] = 1'b0;
      end else if (g_exp[i] != 2'b00) begin
        m_rd[i]   = g_exp[i][1] ? rd1 : rd0;
        m_dat[i]  = g_exp[i][1] ? d1 : d0;
        m_en[i]   = (m_rd[i] != 0);
        m_last[i] = g_exp[i][1];
        m_ptr[i]  = !g_exp[i][1];
        $display("%0t %s write from req%0d rd=%0d data=%08h", $time, nm, g_exp[i][1], m_rd[i], m_dat[i]);
      end else begin
        m_en[i] = 1'b0;
      end
      check({nm, " wr_en"},      {31'd0, wen[i]}, {31'd0, m_en[i]});
      check({nm, " wr_rd"},      {27'd0, wrd[i]}, {27'd0, m_rd[i]});
      check({nm, " wr_data"},    wdat[i],         m_dat[i]);
      check({nm, " last_grant"}, {31'd0, lg[i]},  {31'd0, m_last[i]});
      check({nm, " fwd_a_hit"},  {31'd0, fa[i]},
            {31'd0, m_en[i] && (m_rd[i] == rs1) && (rs1 != 0)});
      check({nm, " fwd_b_hit"},  {31'd0, fb[i]},
            {31'd0, m_en[i] && (m_rd[i] == rs2) && (rs2 != 0)});
    end
  endtask

  task automatic do_reset();
    r_in = 1'b1; hold = 1'b0; v0 = 1'b0; v1 = 1'b0;
    cycle();
    r_in = 1'b0;
  endtask

  initial begin
    r_in = 1'b1; hold = 1'b0; v0 = 1'b1; v1 = 1'b0;
    rd0 = 5'd5; d0 = 32'hDEADBEEF; rd1 = 5'd0; d1 = '0; rs1 = '0; rs2 = '0;

    // reset held two cycles with req0 pending
    cycle();
    cycle();
    check("reset wr_en", {31'd0, wen[0]}, 32'd0);
    check("reset wr_data", wdat[0], 32'd0);

    // single write after release: one-cycle pulse with rd=5
    r_in = 1'b0;
    cycle();
    check("first write rd", {27'd0, wrd[0]}, 32'd5);
    check("first write data", wdat[0], 32'hDEADBEEF);
    v0 = 1'b0;
    cycle();
    check("first write pulse end", {31'd0, wen[0]}, 32'd0);

    // round-robin contention, requesters advance on their own (rr) ready
    do_reset();
    v0 = 1'b1; v1 = 1'b1; rd0 = 5'd1; rd1 = 5'd9; d0 = 32'h100; d1 = 32'h900;
    for (int k = 0; k < 4; k++) begin
      cycle();
      check("rr grant order", {31'd0, lg[0]}, k[31:0] & 32'd1);
      if (g_exp[0][0]) begin rd0 = rd0 + 5'd1; d0 = d0 + 32'h1; end
      if (g_exp[0][1]) begin rd1 = rd1 + 5'd1; d1 = d1 + 32'h1; end
    end
    // req0 drops: fixed-priority instance now serves req1
    v0 = 1'b0;
    cycle();
    check("fp req1 after req0 idle", {31'd0, lg[1]}, 32'd1);
    v1 = 1'b0;
    cycle();

    // x0 write: accepted, no write pulse
    v1 = 1'b1; rd1 = 5'd0; d1 = 32'h12345678; rs1 = 5'd0;
    cycle();
    check("x0 wr_en", {31'd0, wen[0]}, 32'd0);
    v1 = 1'b0;
    cycle();

    // forwarding hit on rs1 only, then idle
    v0 = 1'b1; rd0 = 5'd7; d0 = 32'hA5A5A5A5; rs1 = 5'd7; rs2 = 5'd8;
    cycle();
    check("fwd a on staged", {31'd0, fa[0]}, 32'd1);
    v0 = 1'b0;
    cycle();
    check("fwd a after idle", {31'd0, fa[0]}, 32'd0);

    // transfer then hold with both valid: staged write retires, no grants
    v0 = 1'b1; v1 = 1'b1; rd0 = 5'd3; rd1 = 5'd4; d0 = 32'h33; d1 = 32'h44;
    cycle();
    hold = 1'b1;
    for (int k = 0; k < 3; k++) cycle();
    hold = 1'b0;
    cycle();

    // reset in the handshake cycle discards the transfer
    r_in = 1'b1;
    cycle();
    check("reset discards write", {31'd0, wen[0]}, 32'd0);
    r_in = 1'b0; v0 = 1'b0; v1 = 1'b0;
    cycle();

    // randomized traffic; requesters keep rd/data stable until rr ready
    for (int k = 0; k < 400; k++) begin
      r_in = ($urandom_range(0, 49) == 0);
      hold = ($urandom_range(0, 7) == 0);
      rs1  = 5'($urandom_range(0, 7));
      rs2  = 5'($urandom_range(0, 7));
      if (!v0) begin
        v0 = $urandom_range(0, 1) == 1; rd0 = 5'($urandom_range(0, 7)); d0 = $urandom;
      end
      if (!v1) begin
        v1 = $urandom_range(0, 1) == 1; rd1 = 5'($urandom_range(0, 7)); d1 = $urandom;
      end
      cycle();
      if (g_exp[0][0]) v0 = 1'b0;
      if (g_exp[0][1]) v1 = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
